// File: rtl/mul_seq_ctrl_if.sv
// ---------------------------------------------------------------------------
// mul_seq_ctrl_if
// Bundles everything the shift-and-add sequencer exchanges with the outside:
// the execute-stage request/response handshake and the operand/result path
// to the shared external carry-lookahead adder.
//
// Signals (direction seen from the sequencer, modport slave):
//   START   in   request, taken only when READY=1
//   MCAND   in   multiplicand (WIDTH)
//   MPLIER  in   multiplier (WIDTH)
//   ADDEND  in   accumulate term (WIDTH), only with MUL_SEQ_MAC_EN defined
//   READY   out  sequencer idle, can accept
//   BUSY    out  multiply in progress (CALC or FIN)
//   DONE    out  one-cycle pulse, PROD valid
//   PROD    out  product (2*WIDTH)
//   ADD_A   out  adder operand A
//   ADD_B   out  adder operand B
//   ADD_CI  out  adder carry-in (always 0)
//   ADD_S   in   adder sum, combinational return
//   ADD_CO  in   adder carry-out, combinational return
//
// The master modport is the execute stage plus the adder, i.e. the mirror.
// Optional feature macro: MUL_SEQ_MAC_EN (adds ADDEND).
// ---------------------------------------------------------------------------
interface mul_seq_ctrl_if #(
    parameter int WIDTH = 8
);
    logic                 START;
    logic [WIDTH-1:0]     MCAND;
    logic [WIDTH-1:0]     MPLIER;
`ifdef MUL_SEQ_MAC_EN
    logic [WIDTH-1:0]     ADDEND;
`endif
    logic                 READY;
    logic                 BUSY;
    logic                 DONE;
    logic [2*WIDTH-1:0]   PROD;
    logic [WIDTH-1:0]     ADD_A;
    logic [WIDTH-1:0]     ADD_B;
    logic                 ADD_CI;
    logic [WIDTH-1:0]     ADD_S;
    logic                 ADD_CO;

    modport slave (
        input  START, MCAND, MPLIER,
`ifdef MUL_SEQ_MAC_EN
        input  ADDEND,
`endif
        input  ADD_S, ADD_CO,
        output READY, BUSY, DONE, PROD,
        output ADD_A, ADD_B, ADD_CI
    );

    modport master (
        output START, MCAND, MPLIER,
`ifdef MUL_SEQ_MAC_EN
        output ADDEND,
`endif
        output ADD_S, ADD_CO,
        input  READY, BUSY, DONE, PROD,
        input  ADD_A, ADD_B, ADD_CI
    );
endinterface

// File: rtl/mul_seq_ctrl.sv
// ---------------------------------------------------------------------------
// mul_seq_ctrl
// Unsigned WIDTH x WIDTH -> 2*WIDTH shift-and-add multiplier that borrows an
// external WIDTH-bit adder. One iteration per clock: the adder adds the
// multiplicand (gated by the current multiplier LSB) onto the accumulator,
// and the (carry, sum) pair is shifted right one place into {ACC, Q}.
//
// Ports:
//   CLK   in   clock, rising edge
//   RSTn  in   synchronous reset, active-low
//   bus   mul_seq_ctrl_if.slave (handshake + adder operand/result path)
//
// Timing: accept at E0, CALC at E1..E(WIDTH), DONE high for the cycle after
// E(WIDTH), READY again after E(WIDTH+1).
//
// Optional feature macro: MUL_SEQ_MAC_EN -- accumulator starts at ADDEND so
// the result is MCAND*MPLIER + ADDEND.
// ---------------------------------------------------------------------------
module mul_seq_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic              CLK,
    input  logic              RSTn,
    mul_seq_ctrl_if.slave     bus
);
    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIN} state_t;

    state_t               r_state;
    logic [WIDTH-1:0]     r_acc;
    logic [WIDTH-1:0]     r_q;
    logic [WIDTH-1:0]     r_m;
    logic [CNT_W-1:0]     r_cnt;
    logic [2*WIDTH-1:0]   r_prod;
    logic                 r_ready;
    logic                 r_busy;
    logic                 r_done;

    logic                 w_calc;
    logic [WIDTH-1:0]     w_add_b;
    logic [WIDTH-1:0]     w_acc_next;
    logic [WIDTH-1:0]     w_q_next;
    logic [WIDTH-1:0]     w_acc_init;

    assign w_calc = (r_state == S_CALC);

    // Operand B is M masked by Q[0]; also forced to zero outside CALC so
    // the shared adder sees no activity while we are idle.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_add_b
            assign w_add_b[gi] = w_calc & r_q[0] & r_m[gi];
        end
    endgenerate

    assign bus.ADD_A  = w_calc ? r_acc : '0;
    assign bus.ADD_B  = w_add_b;
    assign bus.ADD_CI = 1'b0;

    // Shift the (WIDTH+1)-bit adder result right by one into {ACC, Q}:
    // carry becomes ACC MSB, sum LSB falls into the top of Q.
    assign w_acc_next = {bus.ADD_CO, bus.ADD_S[WIDTH-1:1]};
    assign w_q_next   = {bus.ADD_S[0], r_q[WIDTH-1:1]};

`ifdef MUL_SEQ_MAC_EN
    assign w_acc_init = bus.ADDEND;
`else
    assign w_acc_init = '0;
`endif

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            r_state <= S_IDLE;
            r_acc   <= '0;
            r_q     <= '0;
            r_m     <= '0;
            r_cnt   <= '0;
            r_prod  <= '0;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.START) begin
                        r_m     <= bus.MCAND;
                        r_q     <= bus.MPLIER;
                        r_acc   <= w_acc_init;
                        r_cnt   <= '0;
                        r_state <= S_CALC;
                        r_ready <= 1'b0;
                        r_busy  <= 1'b1;
                    end
                end
                S_CALC: begin
                    r_acc <= w_acc_next;
                    r_q   <= w_q_next;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CNT_W'(WIDTH - 1)) begin
                        // Last iteration: capture the shifted result directly.
                        r_prod  <= {w_acc_next, w_q_next};
                        r_done  <= 1'b1;
                        r_state <= S_FIN;
                    end
                end
                S_FIN: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.READY = r_ready;
    assign bus.BUSY  = r_busy;
    assign bus.DONE  = r_done;
    assign bus.PROD  = r_prod;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mul_seq_ctrl
// Directed bench for mul_seq_ctrl with an ideal behavioural adder attached.
// Expected products are queued when a request is issued; a monitor pops and
// compares on every DONE pulse. Handshake timing and adder-drive properties
// are checked inline by the stimulus process.
// ---------------------------------------------------------------------------
module tb_mul_seq_ctrl;
    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    logic CLK;
    logic RSTn;

    mul_seq_ctrl_if #(.WIDTH(WIDTH)) bus ();

    mul_seq_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .CLK  (CLK),
        .RSTn (RSTn),
        .bus  (bus.slave)
    );

    // External carry-lookahead adder stand-in
    assign {bus.ADD_CO, bus.ADD_S} = {1'b0, bus.ADD_A} + {1'b0, bus.ADD_B}
                                   + {{WIDTH{1'b0}}, bus.ADD_CI};

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_errors = 0;
    logic [2*WIDTH-1:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks = n_checks + 1;
        if (act !== req) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    // Scoreboard monitor: every DONE pulse must match the oldest queued product
    always @(negedge CLK) begin
        if (RSTn && bus.DONE === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks = n_checks + 1;
                n_errors = n_errors + 1;
                $display("FAIL unexpected_done: PROD=0x%0h with empty queue", bus.PROD);
            end else begin
                logic [2*WIDTH-1:0] e;
                e = exp_q.pop_front();
                check("prod", 32'(bus.PROD), 32'(e));
                $display("txn: PROD=0x%04h expected 0x%04h", bus.PROD, e);
            end
        end
    end

    task automatic set_addend(input logic [WIDTH-1:0] ad);
`ifdef MUL_SEQ_MAC_EN
        bus.ADDEND = ad;
`else
        if (ad != '0) $display("note: addend ignored without MAC option");
`endif
    endtask

    // Bounded wait (at negedges) for READY
    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (bus.READY !== 1'b1 && n < 50) begin
            @(negedge CLK);
            n++;
        end
        if (bus.READY !== 1'b1) begin
            n_checks = n_checks + 1;
            n_errors = n_errors + 1;
            $display("FAIL %s_ready_timeout: READY never rose", tag);
        end
    endtask

    // Issue one multiply, follow it to DONE and check latency/adder drive.
    // Called and returns at a negedge.
    task automatic run_mul(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input logic [WIDTH-1:0] ad, input logic [2*WIDTH-1:0] exp_p,
                           input string tag, output bit co_seen, output bit b_nonzero);
        int lat;
        co_seen = 1'b0;
        b_nonzero = 1'b0;
        wait_ready(tag);
        bus.MCAND  = a;
        bus.MPLIER = b;
        set_addend(ad);
        bus.START  = 1'b1;
        exp_q.push_back(exp_p);
        @(posedge CLK);
        @(negedge CLK);
        bus.START  = 1'b0;
        bus.MCAND  = ~a;           // late operand changes must not matter
        bus.MPLIER = ~b;
        set_addend(~ad);
        lat = 1;
        while (bus.DONE !== 1'b1 && lat < 20) begin
            if (bus.ADD_CO === 1'b1) co_seen = 1'b1;
            if (bus.ADD_B != '0) b_nonzero = 1'b1;
            @(negedge CLK);
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(WIDTH + 1));
        check({tag, "_fin_adder_idle"}, {16'd0, bus.ADD_A, bus.ADD_B}, 32'd0);
        @(negedge CLK);
        check({tag, "_ready_after"}, {30'd0, bus.READY, bus.BUSY}, 32'b10);
    endtask

    initial begin
        bit co, bnz;
        int n;
        RSTn       = 1'b0;
        bus.START  = 1'b0;
        bus.MCAND  = '0;
        bus.MPLIER = '0;
        set_addend('0);

        // Reset state
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check("reset_flags", {29'd0, bus.READY, bus.BUSY, bus.DONE}, 32'b100);
        check("reset_prod", 32'(bus.PROD), 32'd0);
        check("reset_adder", {15'd0, bus.ADD_A, bus.ADD_B, bus.ADD_CI}, 32'd0);
        RSTn = 1'b1;
        @(negedge CLK);

        // Basic and boundary products
        run_mul(8'd13, 8'd11, 8'd0, 16'h008F, "mul13x11", co, bnz);
        run_mul(8'hFF, 8'hFF, 8'd0, 16'hFE01, "mulmax", co, bnz);
        check("mulmax_co_seen", 32'(co), 32'd1);
        run_mul(8'hA5, 8'h00, 8'd0, 16'h0000, "mulzero", co, bnz);
        check("mulzero_addb_zero", 32'(bnz), 32'd0);
        run_mul(8'h01, 8'h80, 8'd0, 16'h0080, "mul1x80", co, bnz);

        // Back-to-back: START held high through CALC/FIN
        wait_ready("b2b");
        bus.MCAND = 8'd3; bus.MPLIER = 8'd5; bus.START = 1'b1;
        exp_q.push_back(16'h000F);
        exp_q.push_back(16'h003F);
        @(posedge CLK);
        @(negedge CLK);
        bus.MCAND = 8'd7; bus.MPLIER = 8'd9;
        n = 1;
        while (bus.DONE !== 1'b1 && n < 20) begin
            @(negedge CLK);
            n++;
        end
        check("b2b_first_latency", 32'(n), 32'(WIDTH + 1));
        @(negedge CLK);
        check("b2b_ready_idle", 32'(bus.READY), 32'd1);
        check("b2b_prod_held", 32'(bus.PROD), 32'h000F);
        @(posedge CLK);            // second accept
        @(negedge CLK);
        bus.START = 1'b0;
        check("b2b_busy_after_accept", {30'd0, bus.READY, bus.BUSY}, 32'b01);
        check("b2b_prod_still_held", 32'(bus.PROD), 32'h000F);
        n = 1;
        while (bus.DONE !== 1'b1 && n < 20) begin
            @(negedge CLK);
            n++;
        end
        check("b2b_second_latency", 32'(n), 32'(WIDTH + 1));
        @(negedge CLK);

        // Reset during the 4th CALC cycle aborts and clears PROD
        wait_ready("rst");
        bus.MCAND = 8'd200; bus.MPLIER = 8'd100; bus.START = 1'b1;
        @(posedge CLK);
        @(negedge CLK);            // 1st CALC cycle
        bus.START = 1'b0;
        repeat (3) @(negedge CLK); // 4th CALC cycle
        RSTn = 1'b0;
        @(negedge CLK);
        check("rst_flags", {29'd0, bus.READY, bus.BUSY, bus.DONE}, 32'b100);
        check("rst_prod", 32'(bus.PROD), 32'd0);
        check("rst_adder", {16'd0, bus.ADD_A, bus.ADD_B}, 32'd0);
        RSTn = 1'b1;
        @(negedge CLK);
        run_mul(8'd2, 8'd2, 8'd0, 16'h0004, "mul2x2", co, bnz);

`ifdef MUL_SEQ_MAC_EN
        run_mul(8'hFF, 8'hFF, 8'hFF, 16'hFF00, "macmax", co, bnz);
        run_mul(8'h34, 8'h00, 8'h12, 16'h0012, "macaddend", co, bnz);
`endif

        repeat (3) @(negedge CLK);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/mul_seq_ctrl.md
Name: mul_seq_ctrl

Overview:
Sequencer that time-shares one external WIDTH-bit carry-lookahead adder (the 8-bit CLA instance in the ALU datapath) to perform an unsigned shift-and-add multiply, WIDTH x WIDTH -> 2*WIDTH. It owns the multiplicand, accumulator and multiplier/shift registers, and drives the adder operands each cycle. It consumes the adder's sum and carry-out in the same cycle. It sits between the microprocessor's execute stage (START/READY/DONE handshake) and the adder.

Parameters:
WIDTH, 8, operand width; must equal the attached adder width.
CNT_W, 4, iteration counter width; must satisfy 2**CNT_W > WIDTH.

Ports:
CLK  input  1  clock; all state updates on the rising edge
RSTn  input  1  synchronous reset, active-low
START  input  1  request; accepted only on an edge where START=1 and READY=1
MCAND  input  WIDTH  multiplicand; sampled at the accept edge
MPLIER  input  WIDTH  multiplier; sampled at the accept edge
READY  output  1  high only in IDLE
BUSY  output  1  high in CALC and FIN
DONE  output  1  one-cycle pulse; PROD is valid
PROD  output  2*WIDTH  registered product; held until the next accept
ADD_A  output  WIDTH  adder operand A
ADD_B  output  WIDTH  adder operand B
ADD_CI  output  1  adder carry-in; constant 0
ADD_S  input  WIDTH  adder sum (combinational return)
ADD_CO  input  1  adder carry-out (combinational return)

Behaviour:
- Clocking and reset: single clock CLK. Reset is synchronous, active-low (RSTn).
- Reset values, after any edge with RSTn=0:
  - state=IDLE
  - ACC=0, Q=0, M=0, cnt=0
  - PROD=0, DONE=0, BUSY=0, READY=1
  - ADD_A=0, ADD_B=0, ADD_CI=0
- Reset has priority over all other inputs. Reset mid-operation aborts the multiply and clears PROD.
- States: IDLE, CALC, FIN.
- IDLE:
  - READY=1.
  - START=1 at edge E0 loads M<=MCAND, Q<=MPLIER, ACC<=0, cnt<=0, and moves to CALC.
  - START=0 stays in IDLE.
- CALC, one iteration per cycle:
  - Adder drive: ADD_A=ACC, ADD_B = Q[0] ? M : 0, ADD_CI=0.
  - At the edge: ACC<={ADD_CO, ADD_S[WIDTH-1:1]}, Q<={ADD_S[0], Q[WIDTH-1:1]}, cnt<=cnt+1.
  - The edge where cnt==WIDTH-1 moves to FIN and loads PROD<=next {ACC,Q}.
- FIN:
  - DONE=1, BUSY=1, READY=0 for exactly one cycle.
  - Next edge moves to IDLE.
- Timing: accept edge E0 -> CALC at edges E1..E(WIDTH) -> DONE high in the cycle after E(WIDTH) -> READY high after E(WIDTH+1). Total WIDTH+2 cycles from accept to next accept.
- START while READY=0 (CALC or FIN) is ignored and not queued. MCAND/MPLIER changes after E0 have no effect.
- ADD_A and ADD_B are 0 in IDLE and FIN (no toggling on the shared adder when idle).
- Adder OF output is not used.
- Arithmetic:
  - Unsigned. Result is exact: max (2^WIDTH-1)^2 fits in 2*WIDTH bits.
  - ADD_CO is the only carry source; no internal adder exists.
- PROD is held stable from FIN until the next accept edge, including across ignored STARTs.

Optional Feature:
MUL_SEQ_MAC_EN:
- Defined:
  - Adds input port ADDEND (WIDTH bits), sampled at the accept edge.
  - At accept, ACC<=ADDEND instead of 0, so PROD = MCAND*MPLIER + ADDEND.
  - Max 255*255+255 = 0xFF00 fits; no overflow flag.
  - Timing is unchanged.
- Undefined: no ADDEND port; ACC initialises to 0.

Test Plan:
- Basic multiply: reset, then START with MCAND=13, MPLIER=11 -> DONE exactly 9 cycles after the accept edge (in the cycle after E8); PROD=0x008F; READY returns the following cycle.
- Maximum operands: MCAND=0xFF, MPLIER=0xFF -> PROD=0xFE01; ADD_CO=1 observed during CALC iterations.
- Zero multiplier: MCAND=0xA5, MPLIER=0x00 -> PROD=0x0000; ADD_B=0 on every CALC cycle. Then MCAND=1, MPLIER=0x80 -> PROD=0x0080.
- Busy and back-to-back:
  - START with 3*5, then hold START high with 7*9 during CALC and FIN -> first PROD=0x000F.
  - The second request is accepted only at the first IDLE edge -> PROD=0x003F.
  - PROD stays 0x000F until that accept edge.
- Reset mid-operation: start 200*100, drive RSTn=0 at the 4th CALC cycle -> next edge gives state IDLE, PROD=0, DONE=0, READY=1. A new 2*2 then yields 0x0004.
- MAC option (MUL_SEQ_MAC_EN defined): MCAND=0xFF, MPLIER=0xFF, ADDEND=0xFF -> PROD=0xFF00. With ADDEND=0x12 and MPLIER=0 -> PROD=0x0012.
